quic_pred_gen: RTL and testbench

QUIC_PRED_GEN -- requirements
Module: quic_pred_gen

---
 rtl/quic_pred_pkg.sv | 25 ++
 rtl/quic_pred_lane.sv | 57 +++++
 rtl/quic_pred_gen.sv | 108 ++++++++++
 tb/tb_quic_pred_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/quic_pred_pkg.sv
// Shared mode encodings and the clip helper for the QUIC predictor.
// Optional feature macro: QUIC_PRED_EXT_MODES_EN (enables modes 3..6 and 8).
package quic_pred_pkg;

    typedef enum logic [3:0] {
        PRED_ZERO     = 4'd0,
        PRED_A        = 4'd1,
        PRED_B        = 4'd2,
        PRED_C        = 4'd3,
        PRED_GRAD     = 4'd4,
        PRED_A_HALF   = 4'd5,
        PRED_B_HALF   = 4'd6,
        PRED_AVG      = 4'd7,
        PRED_WEIGHTED = 4'd8
    } pred_mode_e;

    function automatic int clip_sample(input int v, input int max_v);
        if (v < 0)
            return 0;
        if (v > max_v)
            return max_v;
        return v;
    endfunction

endpackage

// File: rtl/quic_pred_lane.sv
// Combinational single-channel predictor: (a, b, c, mode) -> clipped sample.
// Optional feature macro: QUIC_PRED_EXT_MODES_EN.
module quic_pred_lane
    import quic_pred_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    input  logic [3:0]       mode,
    output logic [PIX_W-1:0] pred
);

`ifdef QUIC_PRED_EXT_MODES_EN
    // One bit above PIX_W+3 so 3a+3b-2c cannot overflow before the shift.
    localparam int W = PIX_W + 4;

    logic signed [W-1:0] sa, sb, sc, res;

    assign sa = $signed({4'b0000, a});
    assign sb = $signed({4'b0000, b});
    assign sc = $signed({4'b0000, c});

    always_comb begin
        res = '0;
        case (mode)
            PRED_ZERO:     res = '0;
            PRED_A:        res = sa;
            PRED_B:        res = sb;
            PRED_C:        res = sc;
            PRED_GRAD:     res = sa + sb - sc;
            PRED_A_HALF:   res = sa + ((sb - sc) >>> 1);
            PRED_B_HALF:   res = sb + ((sa - sc) >>> 1);
            PRED_WEIGHTED: res = (sa + sa + sa + sb + sb + sb - sc - sc) >>> 2;
            default:       res = (sa + sb) >>> 1;
        endcase
        pred = PIX_W'(clip_sample(int'(res), (1 << PIX_W) - 1));
    end
`else
    logic [PIX_W:0] sum;
    logic           unused_c;

    assign sum      = {1'b0, a} + {1'b0, b};
    assign unused_c = ^c;

    always_comb begin
        case (mode)
            PRED_ZERO: pred = '0;
            PRED_A:    pred = a;
            PRED_B:    pred = b;
            default:   pred = PIX_W'(sum >> 1);
        endcase
    end
`endif

endmodule

// File: rtl/quic_pred_gen.sv
// QUIC per-channel pixel predictor with run-mode eligibility and run-length tracking.
// Optional feature macro: QUIC_PRED_EXT_MODES_EN (extended predictor modes).
module quic_pred_gen
    import quic_pred_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int NUM_CH = 3,
    parameter int RUN_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pic_start,
    input  logic [15:0]             row,
    input  logic [15:0]             column,
    input  logic [NUM_CH*PIX_W-1:0] pix_a,
    input  logic [NUM_CH*PIX_W-1:0] pix_b,
    input  logic [NUM_CH*PIX_W-1:0] pix_c,
    input  logic [NUM_CH*PIX_W-1:0] pix_d,
    input  logic [3:0]              pred_mode,
    input  logic                    pred_req,
    input  logic [CH_W-1:0]         ch_sel,
    output logic [NUM_CH*PIX_W-1:0] pred_data,
    output logic                    pred_valid,
    output logic [CH_W-1:0]         pred_ch,
    output logic                    run_ok,
    input  logic                    run_start,
    input  logic                    run_step,
    input  logic                    run_end,
    output logic [RUN_W-1:0]        run_len
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    logic [3:0]       eff_mode;
    logic [PIX_W-1:0] lane_out [NUM_CH];
    logic             accept;
    logic [15:0]      last_run_col;

    // Image borders override the requested mode.
    always_comb begin
        eff_mode = pred_mode;
        if (row == 16'd0 && column == 16'd0)
            eff_mode = PRED_ZERO;
        else if (row == 16'd0)
            eff_mode = PRED_A;
        else if (column == 16'd0)
            eff_mode = PRED_B;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        quic_pred_lane #(.PIX_W(PIX_W)) u_lane (
            .a    (pix_a[k*PIX_W +: PIX_W]),
            .b    (pix_b[k*PIX_W +: PIX_W]),
            .c    (pix_c[k*PIX_W +: PIX_W]),
            .mode (eff_mode),
            .pred (lane_out[k])
        );
    end

    assign accept = pred_req && !pic_start && (int'(ch_sel) < NUM_CH);

    assign run_ok = !(run_start || run_step) && (row != 16'd0) && (column > 16'd2)
                    && (column != last_run_col) && (pix_a == pix_d) && (pix_c == pix_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_data  <= '0;
            pred_valid <= 1'b0;
            pred_ch    <= '0;
        end else if (pic_start) begin
            pred_data  <= '0;
            pred_valid <= 1'b0;
        end else begin
            pred_valid <= accept;
            if (accept) begin
                pred_ch <= ch_sel;
                for (int k = 0; k < NUM_CH; k++)
                    if (int'(ch_sel) == k)
                        pred_data[k*PIX_W +: PIX_W] <= lane_out[k];
            end
        end
    end

    // run_end beats run_start beats run_step; the counter saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_len      <= '0;
            last_run_col <= '0;
        end else if (pic_start) begin
            run_len      <= '0;
            last_run_col <= '0;
        end else begin
            if (run_end)
                run_len <= '0;
            else if (run_start)
                run_len <= RUN_W'(1);
            else if (run_step && run_len != RUN_MAX)
                run_len <= run_len + RUN_W'(1);

            if (column == 16'd0)
                last_run_col <= '0;
            else if (run_start || run_step)
                last_run_col <= column;
        end
    end

endmodule

// File: tb/tb_quic_pred_gen.sv
// Directed self-checking bench for quic_pred_gen (default and RUN_W=4 instances).
module tb_quic_pred_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        pic_start;
    logic [15:0] row, column;
    logic [23:0] pix_a, pix_b, pix_c, pix_d;
    logic [3:0]  pred_mode;
    logic        pred_req;
    logic [1:0]  ch_sel;
    logic        run_start, run_step, run_end;

    logic [23:0] pred_data, pred_data4;
    logic        pred_valid, pred_valid4;
    logic [1:0]  pred_ch, pred_ch4;
    logic        run_ok, run_ok4;
    logic [15:0] run_len;
    logic [3:0]  run_len4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quic_pred_gen dut (
        .clk(clk), .reset(reset), .pic_start(pic_start), .row(row), .column(column),
        .pix_a(pix_a), .pix_b(pix_b), .pix_c(pix_c), .pix_d(pix_d),
        .pred_mode(pred_mode), .pred_req(pred_req), .ch_sel(ch_sel),
        .pred_data(pred_data), .pred_valid(pred_valid), .pred_ch(pred_ch), .run_ok(run_ok),
        .run_start(run_start), .run_step(run_step), .run_end(run_end), .run_len(run_len)
    );

    quic_pred_gen #(.RUN_W(4)) dut4 (
        .clk(clk), .reset(reset), .pic_start(pic_start), .row(row), .column(column),
        .pix_a(pix_a), .pix_b(pix_b), .pix_c(pix_c), .pix_d(pix_d),
        .pred_mode(pred_mode), .pred_req(pred_req), .ch_sel(ch_sel),
        .pred_data(pred_data4), .pred_valid(pred_valid4), .pred_ch(pred_ch4), .run_ok(run_ok4),
        .run_start(run_start), .run_step(run_step), .run_end(run_end), .run_len(run_len4)
    );

    function automatic logic [23:0] pack3(input logic [7:0] x0, input logic [7:0] x1,
                                          input logic [7:0] x2);
        return {x2, x1, x0};
    endfunction

    function automatic logic [7:0] lane(input int k);
        return pred_data[k*8 +: 8];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives one pred_req for a cycle starting at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic [15:0] r, input logic [15:0] col, input logic [3:0] m,
                                 input logic [1:0] ch, input logic [23:0] a, input logic [23:0] b,
                                 input logic [23:0] c);
        row       = r;
        column    = col;
        pred_mode = m;
        ch_sel    = ch;
        pix_a     = a;
        pix_b     = b;
        pix_c     = c;
        pred_req  = 1'b1;
        @(negedge clk);
        pred_req  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pic_start = 1'b0; row = '0; column = '0;
        pix_a = '0; pix_b = '0; pix_c = '0; pix_d = '0;
        pred_mode = '0; pred_req = 1'b0; ch_sel = '0;
        run_start = 1'b0; run_step = 1'b0; run_end = 1'b0;

        #3;
        checkOutput("rst_data", 32'(pred_data), 0);
        checkOutput("rst_valid", 32'(pred_valid), 0);
        checkOutput("rst_ch", 32'(pred_ch), 0);
        checkOutput("rst_runlen", 32'(run_len), 0);

        @(negedge clk);
        reset = 1'b0;

        applyStimulus(5, 5, 7, 1, pack3(0, 200, 0), pack3(0, 101, 0), '0);
        checkOutput("avg_valid", 32'(pred_valid), 1);
        checkOutput("avg_ch", 32'(pred_ch), 1);
        checkOutput("avg_lane1", 32'(lane(1)), 150);
        checkOutput("avg_lane0_hold", 32'(lane(0)), 0);

        applyStimulus(5, 5, 1, 3, pack3(44, 44, 44), pack3(44, 44, 44), '0);
        checkOutput("badch_valid", 32'(pred_valid), 0);
        checkOutput("badch_data", 32'(pred_data), 32'(pack3(0, 150, 0)));

`ifdef QUIC_PRED_EXT_MODES_EN
        applyStimulus(4, 4, 4, 0, pack3(250, 0, 0), pack3(250, 0, 0), pack3(10, 0, 0));
        checkOutput("grad_hi", 32'(lane(0)), 255);
        applyStimulus(4, 4, 4, 2, pack3(0, 0, 5), pack3(0, 0, 0), pack3(0, 0, 200));
        checkOutput("grad_lo", 32'(lane(2)), 0);
        applyStimulus(4, 4, 8, 0, pack3(100, 0, 0), pack3(100, 0, 0), pack3(40, 0, 0));
        checkOutput("weighted", 32'(lane(0)), 130);
        applyStimulus(4, 4, 5, 1, pack3(0, 100, 0), pack3(0, 50, 0), pack3(0, 80, 0));
        checkOutput("a_half", 32'(lane(1)), 85);
        applyStimulus(4, 4, 3, 2, pack3(0, 0, 10), pack3(0, 0, 20), pack3(0, 0, 99));
        checkOutput("mode_c", 32'(lane(2)), 99);
`else
        applyStimulus(4, 4, 4, 0, pack3(250, 0, 0), pack3(250, 0, 0), pack3(10, 0, 0));
        checkOutput("grad_hi", 32'(lane(0)), 250);
        applyStimulus(4, 4, 4, 2, pack3(0, 0, 5), pack3(0, 0, 0), pack3(0, 0, 200));
        checkOutput("grad_lo", 32'(lane(2)), 2);
        applyStimulus(4, 4, 8, 0, pack3(100, 0, 0), pack3(100, 0, 0), pack3(40, 0, 0));
        checkOutput("weighted", 32'(lane(0)), 100);
        applyStimulus(4, 4, 5, 1, pack3(0, 100, 0), pack3(0, 50, 0), pack3(0, 80, 0));
        checkOutput("a_half", 32'(lane(1)), 75);
        applyStimulus(4, 4, 3, 2, pack3(0, 0, 10), pack3(0, 0, 20), pack3(0, 0, 99));
        checkOutput("mode_c", 32'(lane(2)), 15);
`endif
        checkOutput("mode_c_ch", 32'(pred_ch), 2);

        applyStimulus(4, 4, 12, 0, pack3(7, 0, 0), pack3(8, 0, 0), pack3(90, 0, 0));
        checkOutput("mode12", 32'(lane(0)), 7);

        applyStimulus(0, 0, 4, 2, pack3(0, 0, 33), pack3(0, 0, 77), pack3(0, 0, 5));
        checkOutput("edge_origin", 32'(lane(2)), 0);
        applyStimulus(0, 7, 4, 2, pack3(0, 0, 33), pack3(0, 0, 77), pack3(0, 0, 5));
        checkOutput("edge_row0", 32'(lane(2)), 33);
        applyStimulus(3, 0, 4, 2, pack3(0, 0, 33), pack3(0, 0, 77), pack3(0, 0, 5));
        checkOutput("edge_col0", 32'(lane(2)), 77);

        pic_start = 1'b1;
        applyStimulus(4, 4, 1, 1, pack3(55, 55, 55), '0, '0);
        pic_start = 1'b0;
        checkOutput("pic_valid", 32'(pred_valid), 0);
        checkOutput("pic_data", 32'(pred_data), 0);

        row = 2; column = 4;
        pix_a = pack3(1, 2, 3); pix_d = pack3(1, 2, 3);
        pix_b = pack3(4, 5, 6); pix_c = pack3(4, 5, 6);
        #1;
        checkOutput("run_ok_idle", 32'(run_ok), 1);
        run_start = 1'b1;
        #1;
        checkOutput("run_ok_inflight", 32'(run_ok), 0);
        @(negedge clk);
        run_start = 1'b0;
        #1;
        checkOutput("run_ok_samecol", 32'(run_ok), 0);
        checkOutput("run_len_start", 32'(run_len), 1);
        run_step = 1'b1;
        repeat (3) @(negedge clk);
        run_step = 1'b0;
        checkOutput("run_len_steps", 32'(run_len), 4);
        column = 5;
        #1;
        checkOutput("run_ok_newcol", 32'(run_ok), 1);
        pix_d = pack3(1, 2, 9);
        #1;
        checkOutput("run_ok_dmiss", 32'(run_ok), 0);
        run_end = 1'b1; run_start = 1'b1;
        @(negedge clk);
        run_end = 1'b0; run_start = 1'b0;
        checkOutput("run_end_prio", 32'(run_len), 0);
        run_start = 1'b1; run_step = 1'b1;
        @(negedge clk);
        run_start = 1'b0; run_step = 1'b0;
        checkOutput("start_over_step", 32'(run_len), 1);

        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        run_step = 1'b1;
        repeat (20) @(negedge clk);
        run_step = 1'b0;
        checkOutput("sat_run4", 32'(run_len4), 15);
        checkOutput("run16_count", 32'(run_len), 21);

        applyStimulus(1, 1, 1, 0, pack3(9, 0, 0), '0, '0);
        checkOutput("pre_reset_lane0", 32'(lane(0)), 9);

        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_run4", 32'(run_len4), 0);
        checkOutput("async_run16", 32'(run_len), 0);
        checkOutput("async_data", 32'(pred_data), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
